// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control sequencer.
package stopwatch_pkg;

  // Run/paused state encoding.
  typedef enum logic {
    StRun    = 1'b0,
    StPaused = 1'b1
  } state_e;

  // Board-level defaults; simulation overrides DEBOUNCE_CYCLES with a small value.
  localparam int unsigned DefDebounceCycles = 65536;
  localparam int unsigned DefSyncStages     = 2;

endpackage

// File: rtl/debounce_pulse.sv
// Debouncer: emits a single-cycle press pulse after DEBOUNCE_CYCLES consecutive
// high samples of a synchronized input. The count saturates, so holding the
// button gives exactly one pulse; any low sample restarts the count.
module debounce_pulse import stopwatch_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Next count and press pulse; the pulse fires on the step that reaches CntMax.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!in) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d   = cnt_q + 1'b1;
      press_d = (cnt_d == CntMax);
    end
  end

  // Counter and press register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: synchronizes the switches, debounces the pause
// button, tracks run/paused state and produces registered increment pulses and
// blink masks for the digit counters and display driver.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned SYNC_STAGES     = DefSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1hz,
  input  logic tick_2hz,
  input  logic sel,
  input  logic adj,
  input  logic pause,
  output logic inc_sec,
  output logic inc_min,
  output logic blank_sec,
  output logic blank_min,
  output logic running
);

  localparam int unsigned WarmW = $clog2(SYNC_STAGES + 1);
  localparam logic [WarmW-1:0] WarmMax = WarmW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sel_sync_q, adj_sync_q, pause_sync_q;
  logic                   sel_s, adj_s, pause_s;

  logic [WarmW-1:0] warm_q, warm_d;
  logic             armed_q, armed_d;
  logic             press;

  state_e state_q, state_d;
  logic   phase_q, phase_d;
  logic   inc_sec_q, inc_sec_d;
  logic   inc_min_q, inc_min_d;
  logic   blank_sec_q, blank_sec_d;
  logic   blank_min_q, blank_min_d;
  logic   running_q, running_d;

  // Multi-flop synchronizers for the asynchronous switch and button inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_sync_q   <= '0;
      adj_sync_q   <= '0;
      pause_sync_q <= '0;
    end else begin
      sel_sync_q[0]   <= sel;
      adj_sync_q[0]   <= adj;
      pause_sync_q[0] <= pause;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sel_sync_q[i]   <= sel_sync_q[i-1];
        adj_sync_q[i]   <= adj_sync_q[i-1];
        pause_sync_q[i] <= pause_sync_q[i-1];
      end
    end
  end

  assign sel_s   = sel_sync_q[SYNC_STAGES-1];
  assign adj_s   = adj_sync_q[SYNC_STAGES-1];
  assign pause_s = pause_sync_q[SYNC_STAGES-1];

  // Press arming: the synchronizer is cleared by reset, so a button held through
  // reset would look like a fresh rising edge. Only arm once the synchronizer has
  // refilled and shown the button released.
  always_comb begin
    warm_d  = (warm_q == WarmMax) ? warm_q : warm_q + 1'b1;
    armed_d = armed_q | ((warm_q == WarmMax) & ~pause_s);
  end

  // Arming state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      warm_q  <= warm_d;
      armed_q <= armed_d;
    end
  end

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .in   (pause_s & armed_q),
    .press(press)
  );

  // Next state, blink phase and output values; increments use the pre-toggle state.
  always_comb begin
    state_d = state_q;
    if (press) begin
      state_d = (state_q == StRun) ? StPaused : StRun;
    end

    phase_d = adj_s ? (phase_q ^ tick_2hz) : 1'b0;

    inc_sec_d = 1'b0;
    inc_min_d = 1'b0;
    if (state_q == StRun) begin
      if (!adj_s) begin
        inc_sec_d = tick_1hz;
      end else if (sel_s) begin
        inc_sec_d = tick_2hz;
      end else begin
        inc_min_d = tick_2hz;
      end
    end

    blank_min_d = adj_s & ~sel_s & phase_d;
    blank_sec_d = adj_s & sel_s & phase_d;
    running_d   = (state_d == StRun);
  end

  // State, phase and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      phase_q     <= 1'b0;
      inc_sec_q   <= 1'b0;
      inc_min_q   <= 1'b0;
      blank_sec_q <= 1'b0;
      blank_min_q <= 1'b0;
      running_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      inc_sec_q   <= inc_sec_d;
      inc_min_q   <= inc_min_d;
      blank_sec_q <= blank_sec_d;
      blank_min_q <= blank_min_d;
      running_q   <= running_d;
    end
  end

  assign inc_sec   = inc_sec_q;
  assign inc_min   = inc_min_q;
  assign blank_sec = blank_sec_q;
  assign blank_min = blank_min_q;
  assign running   = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: a vector table, hand-written corner sequences
// and a randomized run, all checked against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_1hz = 1'b0;
  logic tick_2hz = 1'b0;
  logic sel = 1'b0;
  logic adj = 1'b0;
  logic pause = 1'b0;
  logic inc_sec, inc_min, blank_sec, blank_min, running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .sel      (sel),
    .adj      (adj),
    .pause    (pause),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .blank_sec(blank_sec),
    .blank_min(blank_min),
    .running  (running)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  bit m_sel_h[S];
  bit m_adj_h[S];
  bit m_pause_h[S];
  bit m_run = 1'b1;
  bit m_phase = 1'b0;
  int m_len = 0;
  bit m_armed = 1'b0;
  int m_warm = 0;
  bit m_press = 1'b0;
  bit e_inc_sec = 1'b0, e_inc_min = 1'b0, e_blank_sec = 1'b0, e_blank_min = 1'b0;
  bit e_running = 1'b1;

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    bit ss, as, ps;
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        m_sel_h[i] = 1'b0;
        m_adj_h[i] = 1'b0;
        m_pause_h[i] = 1'b0;
      end
      m_run = 1'b1; m_phase = 1'b0; m_len = 0; m_armed = 1'b0; m_warm = 0; m_press = 1'b0;
      e_inc_sec = 1'b0; e_inc_min = 1'b0; e_blank_sec = 1'b0; e_blank_min = 1'b0;
      e_running = 1'b1;
      return;
    end
    ss = m_sel_h[S-1];
    as = m_adj_h[S-1];
    ps = m_pause_h[S-1];
    e_inc_sec = m_run && (as ? (ss && tick_2hz) : tick_1hz);
    e_inc_min = m_run && as && !ss && tick_2hz;
    if (m_press) m_run = !m_run;
    m_phase = as ? (m_phase ^ tick_2hz) : 1'b0;
    e_blank_min = as && !ss && m_phase;
    e_blank_sec = as && ss && m_phase;
    e_running = m_run;
    // A press is the moment an armed high run of the synchronized button reaches D.
    m_press = 1'b0;
    if (ps && m_armed) begin
      m_len++;
      if (m_len == D) m_press = 1'b1;
    end else begin
      m_len = 0;
    end
    if (m_warm >= S && !ps) m_armed = 1'b1;
    if (m_warm < S) m_warm++;
    for (int i = S - 1; i > 0; i--) begin
      m_sel_h[i] = m_sel_h[i-1];
      m_adj_h[i] = m_adj_h[i-1];
      m_pause_h[i] = m_pause_h[i-1];
    end
    m_sel_h[0] = sel;
    m_adj_h[0] = adj;
    m_pause_h[0] = pause;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, update the model, then compare all outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk("inc_sec", inc_sec, e_inc_sec);
    chk("inc_min", inc_min, e_inc_min);
    chk("blank_sec", blank_sec, e_blank_sec);
    chk("blank_min", blank_min, e_blank_min);
    chk("running", running, e_running);
    chk("inc_exclusive", inc_sec & inc_min, 1'b0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick_step(input logic t1, input logic t2);
    tick_1hz = t1;
    tick_2hz = t2;
    step();
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
  endtask

  typedef struct {
    bit r, t1, t2, s, a, p;
    bit is, im, bs, bm, run;
  } vec_t;

  function automatic vec_t mk(bit r, bit t1, bit t2, bit s, bit a, bit p,
                              bit is, bit im, bit bs, bit bm, bit run);
    vec_t v;
    v.r = r; v.t1 = t1; v.t2 = t2; v.s = s; v.a = a; v.p = p;
    v.is = is; v.im = im; v.bs = bs; v.bm = bm; v.run = run;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int n;
    int hold_left;

    // Reset, normal run (five 1 Hz ticks, 2 Hz ignored), then minute adjust.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,1,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,1,0, 0,1,0,1,1));
    tbl.push_back(mk(0,1,1,0,1,0, 0,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,1,0, 0,1,0,1,1));
    tbl.push_back(mk(0,1,1,0,1,0, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,1));

    @(negedge clk);
    foreach (tbl[k]) begin
      rst = tbl[k].r; tick_1hz = tbl[k].t1; tick_2hz = tbl[k].t2;
      sel = tbl[k].s; adj = tbl[k].a; pause = tbl[k].p;
      step();
      chk("tbl_inc_sec", inc_sec, tbl[k].is);
      chk("tbl_inc_min", inc_min, tbl[k].im);
      chk("tbl_blank_sec", blank_sec, tbl[k].bs);
      chk("tbl_blank_min", blank_min, tbl[k].bm);
      chk("tbl_running", running, tbl[k].run);
    end
    tick_1hz = 1'b0; tick_2hz = 1'b0;

    // Bounced press then a stable hold: one toggle, seven edges after the hold starts.
    adj = 1'b0; sel = 1'b0;
    steps(3);
    pause = 1'b1; step();
    pause = 1'b0; step();
    pause = 1'b1; step(); step();
    pause = 1'b0; step();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pause_toggle", running, (k < 6) ? 1'b1 : 1'b0);
    end
    pause = 1'b0;
    steps(3);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      tick_step(1'b1, 1'b0);
      n += int'(inc_sec);
      step();
    end
    chk("paused_no_inc", n == 0, 1'b1);
    pause = 1'b1; steps(8);
    pause = 1'b0; steps(3);
    chk("resume", running, 1'b1);

    // Second adjust while paused: blink only, no increments.
    pause = 1'b1; steps(8);
    pause = 1'b0; steps(2);
    adj = 1'b1; sel = 1'b1;
    steps(3);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      tick_step(1'b0, 1'b1);
      chk("blink_sec", blank_sec, (k % 2 == 0) ? 1'b1 : 1'b0);
      n += int'(inc_sec) + int'(inc_min);
      step();
    end
    chk("adj_paused_no_inc", n == 0, 1'b1);
    chk("adj_paused_running", running, 1'b0);

    // Press and 1 Hz tick at the same edge in RUN.
    adj = 1'b0; sel = 1'b0; steps(3);
    pause = 1'b1; steps(8);
    pause = 1'b0; steps(2);
    chk("run_before_sim", running, 1'b1);
    pause = 1'b1;
    steps(6);
    tick_step(1'b1, 1'b0);
    chk("sim_inc_sec", inc_sec, 1'b1);
    chk("sim_running", running, 1'b0);

    // Reset mid-count and mid-blink, with the button held through reset.
    pause = 1'b0; steps(3);
    adj = 1'b1; sel = 1'b0; steps(3);
    tick_step(1'b0, 1'b1);
    chk("blink_phase1", blank_min, 1'b1);
    pause = 1'b1;
    steps(5);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst_inc_sec", inc_sec, 1'b0);
    chk("rst_inc_min", inc_min, 1'b0);
    chk("rst_blank_min", blank_min, 1'b0);
    chk("rst_blank_sec", blank_sec, 1'b0);
    chk("rst_running", running, 1'b1);
    n = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      n += int'(!running);
    end
    chk("no_press_after_rst", n == 0, 1'b1);
    pause = 1'b0; steps(4);
    pause = 1'b1; steps(8);
    chk("press_after_release", running, 1'b0);
    pause = 1'b0; steps(3);

    // Randomized traffic against the model.
    hold_left = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold_left == 0) begin
        pause = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 10);
      end
      hold_left--;
      rst = ($urandom_range(0, 299) == 0);
      tick_1hz = ($urandom_range(0, 7) == 0);
      tick_2hz = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) adj = ~adj;
      if ($urandom_range(0, 49) == 0) sel = ~sel;
      step();
    end
    rst = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
